// File: rtl/cmd_issue_port_if.sv
// cmd_issue_port_if: NoC command bus plus ack bus between an issuer and a receiver.
//   out_bus_data[7:0]  header beat, issuer -> receiver
//   out_bus_valid      beat valid, issuer -> receiver
//   bus_grant          issuer may drive the bus (arbiter/receiver side)
//   bus_ready          receiver ready to take a beat
//   ack_valid          ack bus strobe
//   ack_id[1:0]        ack target ID
// Modports: master = issuing end, slave = receiving/acking end.
interface cmd_issue_port_if;
  logic [7:0] out_bus_data;
  logic       out_bus_valid;
  logic       bus_grant;
  logic       bus_ready;
  logic       ack_valid;
  logic [1:0] ack_id;

  modport master (
    output out_bus_data, out_bus_valid,
    input  bus_grant, bus_ready, ack_valid, ack_id
  );

  modport slave (
    input  out_bus_data, out_bus_valid,
    output bus_grant, bus_ready, ack_valid, ack_id
  );
endinterface

// File: rtl/cmd_issue_port.sv
// cmd_issue_port: accepts one command request, serializes it as a 4-beat
// header (opcode byte, then 24-bit address LSB first) on the NoC bus, then
// waits for the CTRL ack or an ack timeout and pulses done.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_enc_dec/dest/source/opcode/address  request fields
//   bus (master modport)     beat bus out, grant/ready/ack in
//   busy                     command in flight
//   done, timeout_err        one-cycle completion pulse and its qualifier
// Optional: define CMD_ISSUE_STATS_EN to add cmd_count and timeout_count.
module cmd_issue_port #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_enc_dec,
  input  logic [1:0]  req_dest,
  input  logic [1:0]  req_source,
  input  logic [1:0]  req_opcode,
  input  logic [23:0] req_address,
  cmd_issue_port_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
`ifdef CMD_ISSUE_STATS_EN
  ,
  output logic [15:0] cmd_count,
  output logic [15:0] timeout_count
`endif
);

  localparam int unsigned TW      = 16;
  localparam logic [1:0]  OP_HASH = 2'd3;
  localparam logic [1:0]  CTRL_ID = 2'b11;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, DONE} state_t;

  state_t        state;
  logic [7:0]    hdr;
  logic [23:0]   addr;
  logic [1:0]    beat_cnt;
  logic [TW-1:0] timer;
  logic          to_flag;

  // Header beat selected by index from the latched command.
  function automatic logic [7:0] beat_of(input logic [1:0] idx,
                                         input logic [7:0] h,
                                         input logic [23:0] a);
    case (idx)
      2'd0:    beat_of = h;
      2'd1:    beat_of = a[7:0];
      2'd2:    beat_of = a[15:8];
      default: beat_of = a[23:16];
    endcase
  endfunction

  // Issuer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      hdr               <= '0;
      addr              <= '0;
      beat_cnt          <= '0;
      timer             <= '0;
      to_flag           <= 1'b0;
      req_ready         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout_err       <= 1'b0;
      bus.out_bus_valid <= 1'b0;
      bus.out_bus_data  <= '0;
`ifdef CMD_ISSUE_STATS_EN
      cmd_count         <= '0;
      timeout_count     <= '0;
`endif
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            hdr       <= {req_enc_dec, 1'b0, req_dest, req_source, req_opcode};
            addr      <= req_address;
            beat_cnt  <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SEND: begin
          // First SEND cycle loads beat 0; afterwards a beat only advances on transfer.
          if (!bus.out_bus_valid) begin
            bus.out_bus_valid <= 1'b1;
            bus.out_bus_data  <= beat_of(beat_cnt, hdr, addr);
          end else if (bus.bus_ready && bus.bus_grant) begin
            if (beat_cnt == 2'd3) begin
              bus.out_bus_valid <= 1'b0;
              if (hdr[1:0] == OP_HASH) begin
                to_flag <= 1'b0;
                state   <= DONE;
              end else begin
                timer <= '0;
                state <= WAIT_ACK;
              end
            end else begin
              beat_cnt         <= beat_cnt + 2'd1;
              bus.out_bus_data <= beat_of(beat_cnt + 2'd1, hdr, addr);
            end
          end
        end
        WAIT_ACK: begin
          // Ack is checked before the timer so an ack in the last cycle wins.
          if (bus.ack_valid && bus.ack_id == CTRL_ID) begin
            to_flag <= 1'b0;
            state   <= DONE;
          end else if (timer == TIMER_LAST) begin
            to_flag <= 1'b1;
            state   <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          done        <= 1'b1;
          timeout_err <= to_flag;
          busy        <= 1'b0;
          state       <= IDLE;
`ifdef CMD_ISSUE_STATS_EN
          cmd_count   <= cmd_count + 16'd1;
          if (to_flag) timeout_count <= timeout_count + 16'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_issue_port.sv
// Scoreboard bench for cmd_issue_port: the driver pushes expected beats and
// completion results, a separate monitor pops and compares them.
module tb_cmd_issue_port;
  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_enc_dec;
  logic [1:0]  req_dest;
  logic [1:0]  req_source;
  logic [1:0]  req_opcode;
  logic [23:0] req_address;
  logic        busy;
  logic        done;
  logic        timeout_err;
`ifdef CMD_ISSUE_STATS_EN
  logic [15:0] cmd_count;
  logic [15:0] timeout_count;
`endif

  cmd_issue_port_if bif ();

  cmd_issue_port #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_enc_dec(req_enc_dec), .req_dest(req_dest), .req_source(req_source),
    .req_opcode(req_opcode), .req_address(req_address),
    .bus(bif.master),
    .busy(busy), .done(done), .timeout_err(timeout_err)
`ifdef CMD_ISSUE_STATS_EN
    , .cmd_count(cmd_count), .timeout_count(timeout_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] beat_q[$];
  logic       done_q[$];
  logic [15:0] exp_cmd = 16'd0;
  logic [15:0] exp_to  = 16'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every transferred beat and every done pulse.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall) begin
          chk("hold_valid", 32'(bif.out_bus_valid), 1);
          chk("hold_data", 32'(bif.out_bus_data), 32'(prev_data));
        end
        if (bif.out_bus_valid && bif.bus_ready && bif.bus_grant) begin
          chk("beat_expected", 32'(beat_q.size() != 0), 1);
          if (beat_q.size() != 0) chk("beat_data", 32'(bif.out_bus_data), 32'(beat_q.pop_front()));
        end
        if (done) begin
          chk("done_expected", 32'(done_q.size() != 0), 1);
          if (done_q.size() != 0) chk("timeout_err", 32'(timeout_err), 32'(done_q.pop_front()));
        end
        prev_stall = bif.out_bus_valid && !(bif.bus_ready && bif.bus_grant);
        prev_data  = bif.out_bus_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_valid"}, 32'(bif.out_bus_valid), 0);
    chk({tag, "_data"}, 32'(bif.out_bus_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_terr"}, 32'(timeout_err), 0);
`ifdef CMD_ISSUE_STATS_EN
    chk({tag, "_cmd_count"}, 32'(cmd_count), 0);
    chk({tag, "_timeout_count"}, 32'(timeout_count), 0);
`endif
  endtask

  // mode: 0 = CTRL ack sampled j cycles into the wait, 1 = no ack,
  //       2 = non-CTRL ack at j then timeout.
  // stall: 0 = continuous, 1 = grant low 3 cycles on beat 1, 2 = random.
  task automatic run_txn(input logic enc, input logic [1:0] dst, input logic [1:0] src,
                         input logic [1:0] op, input logic [23:0] a, input int mode,
                         input int ack_j, input int stall, input bit do_reset);
    logic [7:0] hdr_exp;
    logic       err_exp;
    logic       pending;
    int xfers, stall_cnt, cbreak, kd, kd_exp;

    for (int w = 0; w < 30; w++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk("req_ready_wait", 32'(req_ready), 1);

    hdr_exp = 8'((int'(enc) * 128) + (int'(dst) * 16) + (int'(src) * 4) + int'(op));
    beat_q.push_back(hdr_exp);
    for (int i = 0; i < 3; i++) beat_q.push_back(8'((a >> (8 * i)) & 24'hFF));
    err_exp = (op != 2'd3) && (mode != 0);
    if (!do_reset) begin
      done_q.push_back(err_exp);
      exp_cmd = exp_cmd + 16'd1;
      if (err_exp) exp_to = exp_to + 16'd1;
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_enc_dec = enc; req_dest = dst; req_source = src;
    req_opcode = op; req_address = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_address = 24'($urandom);
    bif.bus_grant = 1'b1;
    bif.bus_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid_low", 32'(bif.out_bus_valid), 0);
    chk("accept_ready_low", 32'(req_ready), 0);
    chk("accept_busy", 32'(busy), 1);

    pending = 1'b0; xfers = 0; stall_cnt = 0; cbreak = -1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      if (pending) xfers++;
      if (xfers == 4) begin cbreak = c; break; end
      #1;
      if (do_reset && xfers == 2) begin
        rst = 1'b1;
        bif.bus_grant = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midreset");
        beat_q.delete();
        exp_cmd = 16'd0;
        exp_to  = 16'd0;
        repeat (2) @(posedge clk);
        chk("reset_no_done", 32'(done), 0);
        #1 rst = 1'b0;
        bif.bus_grant = 1'b1;
        @(negedge clk);
        chk("reset_release_ready", 32'(req_ready), 0);
        return;
      end
      case (stall)
        0: begin bif.bus_grant = 1'b1; bif.bus_ready = 1'b1; end
        1: begin
          bif.bus_ready = 1'b1;
          if (xfers == 1 && stall_cnt < 3) begin bif.bus_grant = 1'b0; stall_cnt++; end
          else bif.bus_grant = 1'b1;
        end
        default: begin
          bif.bus_grant = ($urandom_range(0, 3) != 0);
          bif.bus_ready = ($urandom_range(0, 3) != 0);
        end
      endcase
      // Requests while busy must be ignored.
      req_valid  = 1'($urandom_range(0, 1));
      req_opcode = 2'($urandom);
      @(negedge clk);
      if (c == 0) chk("beat0_latency", 32'(bif.out_bus_valid), 1);
      pending = bif.out_bus_valid && bif.bus_ready && bif.bus_grant;
    end
    chk("beat_count", xfers, 4);
    if (stall == 0) chk("consecutive_beats", cbreak, 4);

    #1;
    req_valid = 1'b0;
    bif.ack_valid = 1'b0;
    @(negedge clk);
    chk("valid_drop", 32'(bif.out_bus_valid), 0);

    kd = 0;
    for (int k = 1; k <= 20; k++) begin
      bif.ack_valid = (op != 2'd3) && (mode != 1) && (k == ack_j);
      bif.ack_id    = (mode == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      @(posedge clk); #1;
      bif.ack_valid = 1'b0;
      @(negedge clk);
      if (done) begin kd = k; break; end
    end
    if (op == 2'd3)     kd_exp = 1;
    else if (mode == 0) kd_exp = ack_j + 1;
    else                kd_exp = TO + 1;
    chk("done_latency", kd, kd_exp);
    chk("done_busy_low", 32'(busy), 0);

    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("ready_after_done", 32'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_enc_dec = 1'b0; req_dest = 2'd0; req_source = 2'd0;
    req_opcode = 2'd0; req_address = 24'd0;
    bif.bus_grant = 1'b1; bif.bus_ready = 1'b1; bif.ack_valid = 1'b0; bif.ack_id = 2'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 32'(req_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", 32'(req_ready), 1);

    run_txn(1'b1, 2'd2, 2'd2, 2'd0, 24'hABCDEF, 0, 3, 0, 1'b0);
    run_txn(1'b0, 2'd0, 2'd1, 2'd2, 24'h000102, 0, 1, 1, 1'b0);
    run_txn(1'b1, 2'd1, 2'd3, 2'd3, 24'h5A5A5A, 1, 1, 0, 1'b0);
    run_txn(1'b0, 2'd3, 2'd0, 2'd1, 24'h123456, 1, 1, 0, 1'b0);
    run_txn(1'b0, 2'd1, 2'd0, 2'd1, 24'h654321, 2, 4, 0, 1'b0);
    run_txn(1'b1, 2'd0, 2'd2, 2'd1, 24'hFEDCBA, 0, TO, 0, 1'b0);
    run_txn(1'b1, 2'd2, 2'd1, 2'd0, 24'h777777, 0, 2, 0, 1'b1);
    run_txn(1'b0, 2'd1, 2'd1, 2'd0, 24'h0A0B0C, 0, 2, 0, 1'b0);
    run_txn(1'b1, 2'd3, 2'd3, 2'd1, 24'h111111, 1, 1, 2, 1'b0);
    run_txn(1'b0, 2'd2, 2'd2, 2'd2, 24'h222222, 0, 5, 2, 1'b0);
`ifdef CMD_ISSUE_STATS_EN
    chk("stats_cmd_3", 32'(cmd_count), 3);
    chk("stats_to_1", 32'(timeout_count), 1);
`endif

    for (int n = 0; n < 30; n++) begin
      run_txn(1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 24'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(1, TO)),
              int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("beat_q_drained", beat_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
`ifdef CMD_ISSUE_STATS_EN
    chk("cmd_count", 32'(cmd_count), 32'(exp_cmd));
    chk("timeout_count", 32'(timeout_count), 32'(exp_to));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
